// File: rtl/sdf_pair_feeder.sv
// Pairs each sample of the second half-frame with the sample D positions earlier,
// presenting registered operand pairs plus twiddle index to a radix-2 butterfly.
module sdf_pair_feeder #(
   parameter int bit_width = 16,
   parameter int LOG2_D    = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        frame_sync,
   input  logic signed [bit_width-1:0] Re_in,
   input  logic signed [bit_width-1:0] Im_in,
   output logic signed [bit_width-1:0] Re_o1,
   output logic signed [bit_width-1:0] Im_o1,
   output logic signed [bit_width-1:0] Re_o2,
   output logic signed [bit_width-1:0] Im_o2,
   output logic [LOG2_D-1:0]           tw_idx,
   output logic                        out_valid,
   output logic                        pair_last
);

   localparam int D = 1 << LOG2_D;
   localparam logic [0:0] PH_FILL = 1'b0;
   localparam logic [0:0] PH_PAIR = 1'b1;
   localparam logic [LOG2_D:0] CNT_ONE = {{LOG2_D{1'b0}}, 1'b1};

   logic [LOG2_D:0]            cnt;
   logic [LOG2_D-1:0]          slot;
   logic [0:0]                 phase;
   logic                       wr_en;
   logic [LOG2_D-1:0]          wr_addr;
   logic [2*bit_width-1:0]     wr_word;
   logic [2*bit_width-1:0]     rd_word;
   logic [2*bit_width-1:0]     mem [D];

   // Low bits of cnt are both the fill slot and, in PAIR, cnt-D.
   always_comb begin
      slot    = cnt[LOG2_D-1:0];
      phase   = cnt[LOG2_D];
      wr_word = {Re_in, Im_in};
      wr_en   = 1'b0;
      wr_addr = slot;
      if (!rst && in_valid) begin
         if (frame_sync) begin
            wr_en   = 1'b1;
            wr_addr = '0;
         end else if (phase == PH_FILL) begin
            wr_en = 1'b1;
         end
      end
   end

   // Buffer is written only in FILL or on sync, so a PAIR read never collides with a write.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_word;
   end

   assign rd_word = mem[slot];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_valid <= 1'b0;
         pair_last <= 1'b0;
         tw_idx    <= '0;
         Re_o1     <= '0;
         Im_o1     <= '0;
         Re_o2     <= '0;
         Im_o2     <= '0;
      end else if (in_valid) begin
         if (frame_sync) begin
            cnt       <= CNT_ONE;
            out_valid <= 1'b0;
         end else if (phase == PH_FILL) begin
            cnt       <= cnt + CNT_ONE;
            out_valid <= 1'b0;
         end else begin
            cnt       <= cnt + CNT_ONE;
            out_valid <= 1'b1;
            pair_last <= (slot == '1);
            tw_idx    <= slot;
            Re_o1     <= rd_word[2*bit_width-1:bit_width];
            Im_o1     <= rd_word[bit_width-1:0];
            Re_o2     <= Re_in;
            Im_o2     <= Im_in;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdf_pair_feeder.sv
// Directed bench for sdf_pair_feeder with D=4, bit_width=16.
module tb_sdf_pair_feeder;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic               frame_sync = 1'b0;
   logic signed [15:0] Re_in = '0;
   logic signed [15:0] Im_in = '0;
   logic signed [15:0] Re_o1, Im_o1, Re_o2, Im_o2;
   logic [1:0]         tw_idx;
   logic               out_valid;
   logic               pair_last;

   int checks = 0;
   int failures = 0;

   sdf_pair_feeder #(.bit_width(16), .LOG2_D(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .frame_sync(frame_sync),
      .Re_in(Re_in), .Im_in(Im_in),
      .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2), .Im_o2(Im_o2),
      .tw_idx(tw_idx), .out_valid(out_valid), .pair_last(pair_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic v, input logic s, input int re, input int im);
      in_valid   = v;
      frame_sync = s;
      Re_in      = re[15:0];
      Im_in      = im[15:0];
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".ov"}, int'(out_valid), 0);
   endtask

   task automatic expect_pair(input string tag, input int r1, input int i1,
                              input int r2, input int i2, input int tw, input int last);
      check({tag, ".ov"},   int'(out_valid), 1);
      check({tag, ".re1"},  int'(Re_o1), r1);
      check({tag, ".im1"},  int'(Im_o1), i1);
      check({tag, ".re2"},  int'(Re_o2), r2);
      check({tag, ".im2"},  int'(Im_o2), i2);
      check({tag, ".tw"},   int'(tw_idx), tw);
      check({tag, ".last"}, int'(pair_last), last);
   endtask

   task automatic expect_reset(input string tag);
      check({tag, ".ov"},   int'(out_valid), 0);
      check({tag, ".last"}, int'(pair_last), 0);
      check({tag, ".tw"},   int'(tw_idx), 0);
      check({tag, ".re1"},  int'(Re_o1), 0);
      check({tag, ".im1"},  int'(Im_o1), 0);
      check({tag, ".re2"},  int'(Re_o2), 0);
      check({tag, ".im2"},  int'(Im_o2), 0);
   endtask

   // One contiguous frame of samples base..base+7, Im = -Re.
   task automatic run_frame(input string tag, input int base);
      for (int k = 0; k < 8; k++) begin
         feed(1'b1, 1'b0, base + k, -(base + k));
         if (k < 4) expect_idle(tag);
         else expect_pair(tag, base + k - 4, -(base + k - 4), base + k, -(base + k),
                          k - 4, (k == 7) ? 1 : 0);
      end
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expect_reset("rst0");
      rst = 1'b0;

      // Continuous frame 1..8, then back-to-back 11..18
      run_frame("cont", 1);
      run_frame("b2b", 11);

      // Gaps after samples 2 and 6; frame_sync without in_valid is ignored
      feed(1'b1, 1'b0, 1, -1); expect_idle("gap1");
      feed(1'b1, 1'b0, 2, -2); expect_idle("gap2");
      feed(1'b0, 1'b1, 77, -77); expect_idle("gapA");
      check("gapA.hold_re2", int'(Re_o2), 18);
      check("gapA.hold_last", int'(pair_last), 1);
      feed(1'b1, 1'b0, 3, -3); expect_idle("gap3");
      feed(1'b1, 1'b0, 4, -4); expect_idle("gap4");
      feed(1'b1, 1'b0, 5, -5); expect_pair("gap5", 1, -1, 5, -5, 0, 0);
      feed(1'b1, 1'b0, 6, -6); expect_pair("gap6", 2, -2, 6, -6, 1, 0);
      feed(1'b0, 1'b0, 0, 0);  expect_idle("gapB");
      check("gapB.hold_re1", int'(Re_o1), 2);
      check("gapB.hold_re2", int'(Re_o2), 6);
      check("gapB.hold_tw", int'(tw_idx), 1);
      feed(1'b1, 1'b0, 7, -7); expect_pair("gap7", 3, -3, 7, -7, 2, 0);
      feed(1'b1, 1'b0, 8, -8); expect_pair("gap8", 4, -4, 8, -8, 3, 1);

      // frame_sync in PAIR phase after 6 samples
      for (int k = 1; k <= 6; k++) begin
         feed(1'b1, 1'b0, k, -k);
         if (k <= 4) expect_idle("pre");
         else expect_pair("pre", k - 4, -(k - 4), k, -k, k - 5, 0);
      end
      feed(1'b1, 1'b1, 100, -100); expect_idle("sync0");
      for (int k = 1; k <= 7; k++) begin
         feed(1'b1, 1'b0, 100 + k, -(100 + k));
         if (k <= 3) expect_idle("sync");
         else expect_pair("sync", 96 + k, -(96 + k), 100 + k, -(100 + k),
                          k - 4, (k == 7) ? 1 : 0);
      end

      // Reset mid-frame with a sample presented
      for (int k = 1; k <= 5; k++) feed(1'b1, 1'b0, 50 + k, -(50 + k));
      check("mid.ov", int'(out_valid), 1);
      rst = 1'b1;
      feed(1'b1, 1'b1, 99, -99);
      expect_reset("rst1");
      rst = 1'b0;
      run_frame("post", 1);

      // Extremes, Im opposite to Re
      for (int k = 0; k < 8; k++) begin
         int re, im;
         re = (k % 2 == 0) ? 32767 : -32768;
         im = (k % 2 == 0) ? -32768 : 32767;
         feed(1'b1, 1'b0, re, im);
         if (k < 4) expect_idle("ext");
         else expect_pair("ext", re, im, re, im, k - 4, (k == 7) ? 1 : 0);
      end

      feed(1'b0, 1'b0, 0, 0); expect_idle("tail");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
